// File: rtl/fixed_rrelu_stream.sv
// fixed_rrelu_stream
//   Pipelined multi-lane randomized leaky ReLU for fixed-point activation
//   streams. Negative inputs are scaled by a slope in Q0.F. In train mode each
//   lane draws the slope from its own LFSR, and the LFSR steps only on
//   accepted train beats. In eval mode the slope is the fixed midpoint. The
//   slope applied to each lane is exported so a backward pass can replay it.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   mode_train          1 = LFSR slope, 0 = eval slope; sampled at input handshake
//   data_in_0           N signed lanes of DATA_IN_0_PRECISION_0 bits (lane i at [i*W +: W])
//   data_in_0_valid/_ready   input handshake
//   data_out_0          N signed lanes of DATA_OUT_0_PRECISION_0 bits
//   slope_out           N unsigned Q0.F slopes of F+1 bits (2^F for x >= 0)
//   data_out_0_valid/_ready  output handshake
module fixed_rrelu_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 16,
  parameter int DATA_OUT_0_PRECISION_1      = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int UPPER                       = 1,
  parameter int LOWER                       = 4,
  parameter logic [31:0] LFSR_POLY          = 32'h04c11db7,
  parameter logic [31:0] LFSR_SEED          = 32'h0000ACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mode_train,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*(DATA_IN_0_PRECISION_1+1)-1:0] slope_out,
  output logic data_out_0_valid,
  input  logic data_out_0_ready
);

  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int F  = DATA_IN_0_PRECISION_1;
  localparam int OW = DATA_OUT_0_PRECISION_0;
  localparam int OF = DATA_OUT_0_PRECISION_1;
  localparam int N  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int SW = F + 1;

  localparam int UPPER_I = 1 << (F - UPPER);
  localparam int LOWER_I = 1 << (F - LOWER);
  localparam logic [SW-1:0] LOWER_V = SW'(LOWER_I);
  localparam logic [SW-1:0] MASK_V  = SW'((UPPER_I - 1) & ~(LOWER_I - 1));
  localparam logic [SW-1:0] EVAL_V  = SW'((UPPER_I + LOWER_I) >> 1);
  localparam logic [SW-1:0] ONE_V   = SW'(1 << F);
  localparam logic [W-1:0]  POLY_W  = W'(LFSR_POLY);

  // Product of a W-bit signed word and an (F+2)-bit zero-extended slope.
  localparam int PW   = W + F + 2;
  localparam int SH_L = (OF > F) ? OF - F : 0;
  localparam int SH_R = (F > OF) ? F - OF : 0;
  // One spare sign bit so the extension below is never a zero replication.
  localparam int RW   = PW + SH_L + 1;

  logic s1_valid_q;
  logic out_valid_q;
  logic [N*W-1:0]  s1_x_q;
  logic [N*SW-1:0] s1_slope_q;
  logic [N*SW-1:0] s1_slope_d;
  logic [N*OW-1:0] out_data_q;
  logic [N*OW-1:0] out_data_d;
  logic [N*SW-1:0] slope_out_q;

  logic s2_en;
  logic s1_en;
  logic in_hs;

  assign s2_en = !out_valid_q | data_out_0_ready;
  assign s1_en = !s1_valid_q | s2_en;
  assign in_hs = data_in_0_valid & s1_en;

  assign data_in_0_ready  = s1_en;
  assign data_out_0_valid = out_valid_q;
  assign data_out_0       = out_data_q;
  assign slope_out        = slope_out_q;

  for (genvar gi = 0; gi < N; gi++) begin : gen_lane
    localparam logic [W-1:0] SEED_RAW = W'(LFSR_SEED) ^ W'(gi * 32'h9E37);
    localparam logic [W-1:0] SEED     = (SEED_RAW == '0) ? '1 : SEED_RAW;

    logic [W-1:0]  lfsr_q;
    logic [W-1:0]  lfsr_d;
    logic [SW-1:0] masked;
    logic [SW-1:0] train_slope;
    logic          x_neg;

    // Left-shifting Galois step. A train beat uses the state it advances to,
    // so the first train beat after reset sees the first post-seed value.
    assign lfsr_d      = {lfsr_q[W-2:0], 1'b0} ^ (lfsr_q[W-1] ? POLY_W : '0);
    assign masked      = lfsr_d[SW-1:0] & MASK_V;
    assign train_slope = (masked < LOWER_V) ? LOWER_V : masked;
    assign x_neg       = data_in_0[gi*W + W - 1];

    assign s1_slope_d[gi*SW +: SW] = !x_neg ? ONE_V : (mode_train ? train_slope : EVAL_V);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lfsr_q <= SEED;
      end else if (in_hs && mode_train) begin
        lfsr_q <= lfsr_d;
      end
    end

    // Stage 2 arithmetic on the registered S1 word and slope.
    logic [W-1:0]  x_s1;
    logic [SW-1:0] sl_s1;
    logic [PW-1:0] x_ext;
    logic [PW-1:0] sl_ext;
    logic [PW-1:0] prod;
    logic signed [PW-1:0] q;
    logic signed [RW-1:0] q_ext;
    logic signed [RW-1:0] r;
    logic [OW-1:0] sat;

    assign x_s1   = s1_x_q[gi*W +: W];
    assign sl_s1  = s1_slope_q[gi*SW +: SW];
    // Sign-extend x and zero-extend the slope to the full product width so an
    // unsigned multiply yields the correct signed low PW bits.
    assign x_ext  = {{(PW-W){x_s1[W-1]}}, x_s1};
    assign sl_ext = {{(PW-SW){1'b0}}, sl_s1};
    assign prod   = x_ext * sl_ext;
    assign q      = $signed(prod) >>> F;
    assign q_ext  = {{(SH_L+1){q[PW-1]}}, q};
    // Only one of SH_L / SH_R is non-zero; the right shift floors.
    assign r      = (q_ext <<< SH_L) >>> SH_R;

    // Saturate when the bits above the output sign bit are not a pure sign extension.
    always_comb begin
      sat = r[OW-1:0];
      if (r[RW-1] && !(&r[RW-1:OW-1])) begin
        sat = {1'b1, {(OW-1){1'b0}}};
      end else if (!r[RW-1] && (|r[RW-1:OW-1])) begin
        sat = {1'b0, {(OW-1){1'b1}}};
      end
    end

    assign out_data_d[gi*OW +: OW] = sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_slope_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      slope_out_q <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= data_in_0_valid;
      end
      if (in_hs) begin
        s1_x_q     <= data_in_0;
        s1_slope_q <= s1_slope_d;
      end
      // Output holds while stalled; it reloads only when S2 may advance.
      if (s2_en) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q  <= out_data_d;
          slope_out_q <= s1_slope_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_rrelu_stream.sv
module tb_fixed_rrelu_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Four-lane instance with default precisions.
  logic        mode_a, valid_a, ready_a, ovalid_a, oready_a;
  logic [63:0] din_a, dout_a;
  logic [35:0] slope_a;

  // Single-lane instance with an 8-bit Q4.4 output for saturation checks.
  logic        mode_b, valid_b, ready_b, ovalid_b, oready_b;
  logic [15:0] din_b;
  logic [7:0]  dout_b;
  logic [8:0]  slope_b;

  fixed_rrelu_stream #(.DATA_IN_0_PARALLELISM_DIM_0(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode_train(mode_a),
    .data_in_0(din_a), .data_in_0_valid(valid_a), .data_in_0_ready(ready_a),
    .data_out_0(dout_a), .slope_out(slope_a),
    .data_out_0_valid(ovalid_a), .data_out_0_ready(oready_a)
  );

  fixed_rrelu_stream #(.DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode_train(mode_b),
    .data_in_0(din_b), .data_in_0_valid(valid_b), .data_in_0_ready(ready_b),
    .data_out_0(dout_b), .slope_out(slope_b),
    .data_out_0_valid(ovalid_b), .data_out_0_ready(oready_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [35:0] slope;
    logic [3:0]  rng;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] mdl_lfsr[4];
  bit          rand_ready = 1'b0;
  int          stall_cycles = 0;
  bit          held_valid = 1'b0;
  logic [63:0] held_data;
  logic [35:0] held_slope;
  bit          lanes_differ = 1'b0;
  int          beats_out = 0;

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1DB7 : 16'h0000);
  endfunction

  function automatic logic [15:0] seed_of(input int i);
    logic [31:0] t;
    t = 32'h0000ACE1 ^ (i * 32'h9E37);
    return (t[15:0] == 16'h0) ? 16'hFFFF : t[15:0];
  endfunction

  function automatic int train_slope(input logic [15:0] s);
    int m;
    m = int'(s & 16'h0070);
    return (m < 16) ? 16 : m;
  endfunction

  function automatic int model_out(input int x, input int sl, input int of_bits, input int ow);
    longint p, q, mx, mn;
    p = longint'(x) * longint'(sl);
    q = p >>> 8;
    if (of_bits < 8) q = q >>> (8 - of_bits);
    else q = q <<< (of_bits - 8);
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (q > mx) q = mx;
    if (q < mn) q = mn;
    return int'(q);
  endfunction

  function automatic exp_t model_beat(input logic [63:0] x, input logic train);
    exp_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] xi;
      int sl;
      xi = x[i*16 +: 16];
      if (train) mdl_lfsr[i] = lfsr_step(mdl_lfsr[i]);
      if (xi < 0) sl = train ? train_slope(mdl_lfsr[i]) : 72;
      else sl = 256;
      r.data[i*16 +: 16] = 16'(model_out(int'(xi), sl, 8, 16));
      r.slope[i*9 +: 9]  = 9'(sl);
      r.rng[i]           = train && (xi < 0);
    end
    return r;
  endfunction

  // ---------------- output back-pressure ----------------
  always @(posedge clk) begin
    #1;
    oready_a = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (held_valid) begin
      tests_run++;
      if (ovalid_a !== 1'b1 || dout_a !== held_data || slope_a !== held_slope) begin
        tests_failed++;
        $display("FAIL stall_hold: valid=%b data=%h slope=%h, required valid=1 data=%h slope=%h",
                 ovalid_a, dout_a, slope_a, held_data, held_slope);
      end
    end
    held_valid = (ovalid_a === 1'b1) && (oready_a === 1'b0);
    held_data  = dout_a;
    held_slope = slope_a;
    if (ovalid_a === 1'b1 && oready_a === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: data=%h slope=%h, required no output", dout_a, slope_a);
      end else begin
        e = sb.pop_front();
        beats_out++;
        $display("[TB] beat %0d data=%h slope=%h", beats_out, dout_a, slope_a);
        if (dout_a !== e.data || slope_a !== e.slope) begin
          tests_failed++;
          $display("FAIL sb_compare: data=%h slope=%h, required data=%h slope=%h",
                   dout_a, slope_a, e.data, e.slope);
        end
        for (int i = 0; i < 4; i++) begin
          if (e.rng[i]) begin
            int s;
            s = int'(slope_a[i*9 +: 9]);
            tests_run++;
            if (s < 16 || s > 112 || (s % 16) != 0) begin
              tests_failed++;
              $display("FAIL train_range: lane %0d slope=%0d, required 16..112 step 16", i, s);
            end
          end
        end
        if (e.rng != 4'b0000 && (slope_a[8:0] !== slope_a[17:9] || slope_a[8:0] !== slope_a[26:18] ||
                                 slope_a[8:0] !== slope_a[35:27]))
          lanes_differ = 1'b1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_beat_a(input logic [63:0] x, input logic train);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    din_a = x;
    mode_a = train;
    valid_a = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ready_a === 1'b1) begin
        sb.push_back(model_beat(x, train));
        done = 1'b1;
      end else begin
        stall_cycles++;
        waited++;
      end
      @(posedge clk);
      #1;
      if (!done && waited > 1000) begin
        tests_run++;
        tests_failed++;
        $display("FAIL handshake_timeout: ready=%b after %0d cycles, required 1", ready_a, waited);
        done = 1'b1;
      end
    end
    valid_a = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    valid_a = 1'b0; mode_a = 1'b0; din_a = '0;
    valid_b = 1'b0; mode_b = 1'b0; din_b = '0; oready_b = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({ovalid_a, dout_a, slope_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a: valid=%b data=%h slope=%h, required all 0", ovalid_a, dout_a, slope_a);
    end
    tests_run++;
    if ({ovalid_b, dout_b, slope_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b: valid=%b data=%h slope=%h, required all 0", ovalid_b, dout_b, slope_b);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl_lfsr[i] = seed_of(i);
    #1;
    tests_run++;
    if ({ready_a, ready_b} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_ready: ready_a=%b ready_b=%b, required 1 1", ready_a, ready_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_eval_latency();
    rand_ready = 1'b0;
    // lanes 3..0: 0x8000, -1, 0x0180, -1.0
    drive_beat_a({16'h8000, 16'hFFFF, 16'h0180, 16'hFF00}, 1'b0);
    tests_run++;
    if (ovalid_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_early: valid=%b one cycle after handshake, required 0", ovalid_a);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (ovalid_a !== 1'b1 || dout_a !== {16'hDC00, 16'hFFFF, 16'h0180, 16'hFFB8} ||
        slope_a !== {9'd72, 9'd72, 9'd256, 9'd72}) begin
      tests_failed++;
      $display("FAIL eval_basic: valid=%b data=%h slope=%h, required valid=1 data=dc00ffff0180ffb8 slope=%h",
               ovalid_a, dout_a, slope_a, {9'd72, 9'd72, 9'd256, 9'd72});
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    rand_ready = 1'b0;
    stall_cycles = 0;
    for (int k = 0; k < 50; k++)
      drive_beat_a({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, 1'b0);
    tests_run++;
    if (stall_cycles != 0) begin
      tests_failed++;
      $display("FAIL throughput: %0d stall cycles, required 0", stall_cycles);
    end
    wait_drain();
  endtask

  task automatic test_train();
    rand_ready = 1'b0;
    lanes_differ = 1'b0;
    for (int k = 0; k < 1000; k++)
      drive_beat_a({1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 15'($urandom)}, 1'b1);
    wait_drain();
    tests_run++;
    if (lanes_differ !== 1'b1) begin
      tests_failed++;
      $display("FAIL lanes_differ: %b, required 1", lanes_differ);
    end
  endtask

  task automatic test_stall();
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      drive_beat_a({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rand_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      drive_beat_a({1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 15'($urandom), 1'b1, 15'($urandom)}, 1'b1);
    #2;
    rst_n = 1'b0;
    held_valid = 1'b0;
    #1;
    tests_run++;
    if ({ovalid_a, dout_a, slope_a} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_clear: valid=%b data=%h slope=%h, required all 0", ovalid_a, dout_a, slope_a);
    end
    sb.delete();
    for (int i = 0; i < 4; i++) mdl_lfsr[i] = seed_of(i);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_beat_a({4{16'hFF00}}, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if (ovalid_a !== 1'b1 || dout_a !== {16'hFFF0, 16'hFFE0, 16'hFFE0, 16'hFF90} ||
        slope_a !== {9'd16, 9'd32, 9'd32, 9'd112}) begin
      tests_failed++;
      $display("FAIL midreset_first_slope: valid=%b data=%h slope=%h, required valid=1 data=fff0ffe0ffe0ff90 slope=%h",
               ovalid_a, dout_a, slope_a, {9'd16, 9'd32, 9'd32, 9'd112});
    end
    wait_drain();
  endtask

  task automatic test_saturation_b();
    logic [15:0] xs [4];
    logic [7:0]  ys [4];
    logic [8:0]  ss [4];
    xs[0] = 16'h7F00; ys[0] = 8'h7F; ss[0] = 9'd256;
    xs[1] = 16'h8100; ys[1] = 8'h80; ss[1] = 9'd72;
    xs[2] = 16'h0123; ys[2] = 8'h12; ss[2] = 9'd256;
    xs[3] = 16'hFF00; ys[3] = 8'hFB; ss[3] = 9'd72;
    oready_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din_b = xs[k];
      mode_b = 1'b0;
      valid_b = 1'b1;
      tests_run++;
      if (ready_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL sat_ready: ready=%b, required 1", ready_b);
      end
      @(posedge clk);
      #1;
      valid_b = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] sat beat x=%h data=%h slope=%0d", xs[k], dout_b, slope_b);
      tests_run++;
      if (ovalid_b !== 1'b1 || dout_b !== ys[k] || slope_b !== ss[k]) begin
        tests_failed++;
        $display("FAIL sat_%0d: x=%h valid=%b data=%h slope=%0d, required valid=1 data=%h slope=%0d",
                 k, xs[k], ovalid_b, dout_b, slope_b, ys[k], ss[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_eval_latency();
    test_back_to_back();
    test_train();
    test_stall();
    test_reset_mid();
    test_saturation_b();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
